// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS-style CP0 control for a multi-slot commit stage.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. Picks the oldest
// excepting slot, raises the redirect, and handles ERET and MTC0 gating.
// Optional build macro CP0_TIMER_INT_EN: Count==Compare raises Cause.TI and
// drives IP7; without it IP7 follows the synchronised hw_int[5].
module cp0_ctrl #(
    parameter int          ISSUE_W    = 2,
    parameter int          TICK_DIV   = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ISSUE_W-1:0]     slot_valid,
    input  logic [32*ISSUE_W-1:0]  slot_pc,
    input  logic [ISSUE_W-1:0]     slot_ds,
    input  logic [7*ISSUE_W-1:0]   slot_exc,
    input  logic [32*ISSUE_W-1:0]  slot_badaddr,
    input  logic [ISSUE_W-1:0]     slot_eret,
    input  logic                   mtc0_we,
    input  logic [1:0]             mtc0_slot,
    input  logic [4:0]             mtc0_addr,
    input  logic [31:0]            mtc0_wdata,
    input  logic [4:0]             mfc0_addr,
    output logic [31:0]            mfc0_rdata,
    input  logic [5:0]             hw_int,
    output logic                   flush,
    output logic [31:0]            flush_pc,
    output logic [ISSUE_W-1:0]     exc_slot
);

    localparam int             DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [1:0]     BAD_NONE = 2'd0;
    localparam logic [1:0]     BAD_PC   = 2'd1;
    localparam logic [1:0]     BAD_ADDR = 2'd2;

    // Exception code of the highest-priority cause within one slot.
    // exc bits: [6]=if_adel [5]=ri [4]=ov [3]=sys [2]=bp [1]=adel [0]=ades
    function automatic logic [4:0] f_exc_code(input logic irq, input logic [6:0] e);
        if (irq)       return 5'd0;
        else if (e[6]) return 5'd4;
        else if (e[5]) return 5'd10;
        else if (e[4]) return 5'd12;
        else if (e[3]) return 5'd8;
        else if (e[2]) return 5'd9;
        else if (e[1]) return 5'd4;
        else           return 5'd5;
    endfunction

    // Which value (if any) the winning cause loads into BadVAddr.
    function automatic logic [1:0] f_bad_src(input logic irq, input logic [6:0] e);
        if (irq)                     return BAD_NONE;
        else if (e[6])               return BAD_PC;
        else if (|e[5:2])            return BAD_NONE;
        else if (e[1] || e[0])       return BAD_ADDR;
        else                         return BAD_NONE;
    endfunction

    logic [5:0]        r_int_s1, r_int_s2;
    logic [DIV_W-1:0]  r_div;
    logic [31:0]       r_count, r_compare, r_badvaddr, r_epc;
    logic [7:0]        r_im;
    logic              r_exl, r_ie, r_bd;
    logic [1:0]        r_ip_sw;
    logic [4:0]        r_exccode;

    logic              w_tick, w_count_wr, w_compare_wr, w_mtc0_ok;
    logic [31:0]       w_count_nxt;
    logic              w_ip7, w_ti, w_int_pending;
    logic [7:0]        w_ip;
    logic              w_found, w_exc_take, w_eret_take, w_sel_ds;
    logic [1:0]        w_exc_idx, w_bad_src;
    logic [ISSUE_W-1:0] w_exc_oh;
    logic [4:0]        w_exc_code;
    logic [31:0]       w_sel_pc, w_sel_ba;

    assign w_ip          = {w_ip7, r_int_s2[4:0], r_ip_sw};
    assign w_int_pending = r_ie && !r_exl && ((w_ip & r_im) != 8'd0);

    // Oldest valid slot with an exception (or the slot-0 interrupt) or an ERET wins.
    always_comb begin
        w_found     = 1'b0;
        w_exc_take  = 1'b0;
        w_eret_take = 1'b0;
        w_exc_idx   = 2'd0;
        w_exc_oh    = '0;
        w_exc_code  = 5'd0;
        w_bad_src   = BAD_NONE;
        w_sel_pc    = 32'd0;
        w_sel_ds    = 1'b0;
        w_sel_ba    = 32'd0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (!w_found && slot_valid[i]) begin
                if ((|slot_exc[7*i +: 7]) || (i == 0 && w_int_pending)) begin
                    w_found     = 1'b1;
                    w_exc_take  = 1'b1;
                    w_exc_idx   = 2'(i);
                    w_exc_oh[i] = 1'b1;
                    w_exc_code  = f_exc_code(i == 0 && w_int_pending, slot_exc[7*i +: 7]);
                    w_bad_src   = f_bad_src(i == 0 && w_int_pending, slot_exc[7*i +: 7]);
                    w_sel_pc    = slot_pc[32*i +: 32];
                    w_sel_ds    = slot_ds[i];
                    w_sel_ba    = slot_badaddr[32*i +: 32];
                end else if (slot_eret[i]) begin
                    w_found     = 1'b1;
                    w_eret_take = 1'b1;
                end
            end
        end
    end

    // An MTC0 commits only if no slot at or older than it takes an exception.
    assign w_mtc0_ok    = mtc0_we && !(w_exc_take && (w_exc_idx <= mtc0_slot));
    assign w_count_wr   = w_mtc0_ok && (mtc0_addr == 5'd9);
    assign w_compare_wr = w_mtc0_ok && (mtc0_addr == 5'd11);
    assign w_tick       = (r_div == DIV_MAX);
    assign w_count_nxt  = w_count_wr ? mtc0_wdata : (r_count + 32'd1);

    // Redirect outputs are held quiet while reset is asserted.
    assign flush    = rst && w_found;
    assign exc_slot = rst ? w_exc_oh : '0;
    assign flush_pc = (rst && w_eret_take) ? r_epc : EXC_VECTOR;

    // Two-flop synchroniser for the external interrupt lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_s1 <= 6'd0;
            r_int_s2 <= 6'd0;
        end else begin
            r_int_s1 <= hw_int;
            r_int_s2 <= r_int_s1;
        end
    end

    // Count advances once per TICK_DIV clocks; a software write reloads it and restarts the divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= '0;
            r_count <= 32'd0;
        end else if (w_count_wr) begin
            r_div   <= '0;
            r_count <= mtc0_wdata;
        end else if (w_tick) begin
            r_div   <= '0;
            r_count <= w_count_nxt;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic r_ti;
    // Timer interrupt latches when Count reaches Compare; a Compare write acknowledges it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ti <= 1'b0;
        end else if (w_compare_wr) begin
            r_ti <= 1'b0;
        end else if ((w_count_wr || w_tick) && (w_count_nxt == r_compare)) begin
            r_ti <= 1'b1;
        end
    end
    assign w_ip7 = r_ti;
    assign w_ti  = r_ti;
`else
    assign w_ip7 = r_int_s2[5];
    assign w_ti  = 1'b0;
`endif

    // Architectural registers: MTC0 first, then ERET, then exception entry overrides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_badvaddr <= 32'd0;
            r_compare  <= 32'd0;
            r_epc      <= 32'd0;
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
        end else begin
            if (w_compare_wr) r_compare <= mtc0_wdata;
            if (w_mtc0_ok && mtc0_addr == 5'd12) begin
                r_im  <= mtc0_wdata[15:8];
                r_exl <= mtc0_wdata[1];
                r_ie  <= mtc0_wdata[0];
            end
            if (w_mtc0_ok && mtc0_addr == 5'd13) r_ip_sw <= mtc0_wdata[9:8];
            if (w_mtc0_ok && mtc0_addr == 5'd14) r_epc   <= mtc0_wdata;
            if (w_eret_take) r_exl <= 1'b0;
            if (w_exc_take) begin
                r_exl     <= 1'b1;
                r_exccode <= w_exc_code;
                // A nested exception keeps the outer EPC/BD so ERET still returns there.
                if (!r_exl) begin
                    r_epc <= w_sel_ds ? (w_sel_pc - 32'd4) : w_sel_pc;
                    r_bd  <= w_sel_ds;
                end
                if (w_bad_src == BAD_PC)   r_badvaddr <= w_sel_pc;
                if (w_bad_src == BAD_ADDR) r_badvaddr <= w_sel_ba;
            end
        end
    end

    // Combinational read of pre-edge register values.
    always_comb begin
        mfc0_rdata = 32'd0;
        case (mfc0_addr)
            5'd8:    mfc0_rdata = r_badvaddr;
            5'd9:    mfc0_rdata = r_count;
            5'd11:   mfc0_rdata = r_compare;
            5'd12:   mfc0_rdata = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
            5'd13:   mfc0_rdata = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};
            5'd14:   mfc0_rdata = r_epc;
            default: mfc0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: a vector table for single-cycle exception
// behaviour plus hand-written sequences for reset, Count, interrupts, ERET,
// MTC0 gating and the optional timer interrupt (CP0_TIMER_INT_EN).
module tb_cp0_ctrl;

    localparam logic [31:0] VEC = 32'hbfc00380;
    localparam logic [31:0] ST0 = 32'h00400000;
`ifdef CP0_TIMER_INT_EN
    localparam logic TIMER_ON = 1'b1;
`else
    localparam logic TIMER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  slot_valid, slot_ds, slot_eret, exc_slot;
    logic [63:0] slot_pc, slot_badaddr;
    logic [13:0] slot_exc;
    logic        mtc0_we;
    logic [1:0]  mtc0_slot;
    logic [4:0]  mtc0_addr, mfc0_addr;
    logic [31:0] mtc0_wdata, mfc0_rdata, flush_pc;
    logic [5:0]  hw_int;
    logic        flush;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] rv;

    cp0_ctrl dut (
        .clk(clk), .rst(rst),
        .slot_valid(slot_valid), .slot_pc(slot_pc), .slot_ds(slot_ds),
        .slot_exc(slot_exc), .slot_badaddr(slot_badaddr), .slot_eret(slot_eret),
        .mtc0_we(mtc0_we), .mtc0_slot(mtc0_slot), .mtc0_addr(mtc0_addr),
        .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .hw_int(hw_int), .flush(flush), .flush_pc(flush_pc), .exc_slot(exc_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid, ds, eret;
        logic [6:0]  e0, e1;
        logic [31:0] pc0, pc1, ba0, ba1;
        logic        xf;
        logic [31:0] xpc;
        logic [1:0]  xslot;
        logic [31:0] xcause, xepc, xbv, xstat;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic [1:0] v, ds, er, input logic [6:0] e0, e1,
                                input logic [31:0] pc0, pc1, ba0, ba1,
                                input logic xf, input logic [31:0] xpc, input logic [1:0] xs,
                                input logic [31:0] xc, xe, xb, xst);
        vec_t t;
        t.valid = v; t.ds = ds; t.eret = er; t.e0 = e0; t.e1 = e1;
        t.pc0 = pc0; t.pc1 = pc1; t.ba0 = ba0; t.ba1 = ba1;
        t.xf = xf; t.xpc = xpc; t.xslot = xs;
        t.xcause = xc; t.xepc = xe; t.xbv = xb; t.xstat = xst;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        slot_valid = 2'b00; slot_ds = 2'b00; slot_eret = 2'b00;
        slot_pc = 64'd0; slot_badaddr = 64'd0; slot_exc = 14'd0;
        mtc0_we = 1'b0; mtc0_slot = 2'd0; mtc0_addr = 5'd0; mtc0_wdata = 32'd0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        mfc0_addr = a;
        #1;
        d = mfc0_rdata;
    endtask

    task automatic do_reset();
        idle();
        hw_int = 6'd0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [1:0] s);
        mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d; mtc0_slot = s;
        step();
        mtc0_we = 1'b0;
    endtask

    initial begin
        // valid ds eret e0 e1 pc0 pc1 ba0 ba1 | flush fpc slot cause epc bv status
        tbl[0]  = mk(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 32'h80000000, 32'h80000004, 0, 0,
                     0, VEC, 2'b00, 32'h0, 32'h0, 32'h0, ST0);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, 7'h20, 7'h00, 32'h80000100, 32'h80000104, 0, 0,
                     1, VEC, 2'b01, 32'h28, 32'h80000100, 32'h0, ST0 | 2);
        tbl[2]  = mk(2'b11, 2'b10, 2'b00, 7'h00, 7'h10, 32'h80000ff0, 32'h80001004, 0, 0,
                     1, VEC, 2'b10, 32'h80000030, 32'h80001000, 32'h0, ST0 | 2);
        tbl[3]  = mk(2'b01, 2'b00, 2'b00, 7'h60, 7'h00, 32'h80000003, 32'h80000007, 0, 0,
                     1, VEC, 2'b01, 32'h10, 32'h80000003, 32'h80000003, ST0 | 2);
        tbl[4]  = mk(2'b01, 2'b00, 2'b00, 7'h06, 7'h00, 32'h80000010, 32'h80000014, 32'h1234, 0,
                     1, VEC, 2'b01, 32'h24, 32'h80000010, 32'h0, ST0 | 2);
        tbl[5]  = mk(2'b11, 2'b00, 2'b00, 7'h00, 7'h01, 32'h80000020, 32'h80000024, 0, 32'hdeadbeef,
                     1, VEC, 2'b10, 32'h14, 32'h80000024, 32'hdeadbeef, ST0 | 2);
        tbl[6]  = mk(2'b11, 2'b00, 2'b10, 7'h08, 7'h00, 32'h80000030, 32'h80000034, 0, 0,
                     1, VEC, 2'b01, 32'h20, 32'h80000030, 32'h0, ST0 | 2);
        tbl[7]  = mk(2'b10, 2'b00, 2'b00, 7'h20, 7'h00, 32'h80000040, 32'h80000044, 0, 0,
                     0, VEC, 2'b00, 32'h0, 32'h0, 32'h0, ST0);
        tbl[8]  = mk(2'b01, 2'b00, 2'b01, 7'h00, 7'h00, 32'h80000048, 32'h8000004c, 0, 0,
                     1, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0, ST0);
        tbl[9]  = mk(2'b11, 2'b01, 2'b00, 7'h10, 7'h08, 32'h80002000, 32'h80002004, 0, 0,
                     1, VEC, 2'b01, 32'h80000030, 32'h80001ffc, 32'h0, ST0 | 2);
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 7'h02, 7'h00, 32'h80000050, 32'h80000054, 32'habc0, 0,
                     1, VEC, 2'b01, 32'h10, 32'h80000050, 32'habc0, ST0 | 2);

        idle();
        hw_int = 6'd0;
        mfc0_addr = 5'd0;

        // Reset state, with an exception presented while reset is held.
        rst = 1'b0;
        #2;
        slot_valid = 2'b01; slot_exc = {7'h00, 7'h20}; slot_pc = {32'h0, 32'h80000100};
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_fpc", flush_pc, VEC);
        chk("rst_slot", {30'd0, exc_slot}, 32'd0);
        step();
        rd(5'd12, rv); chk("rst_status", rv, ST0);
        rd(5'd14, rv); chk("rst_epc", rv, 32'd0);
        rd(5'd13, rv); chk("rst_cause", rv, 32'd0);
        rd(5'd9, rv);  chk("rst_count", rv, 32'd0);
        idle();
        rst = 1'b1;

        // Ten clocks after release with TICK_DIV=2.
        for (int c = 0; c < 10; c++) step();
        rd(5'd9, rv);  chk("count10", rv, 32'd5);
        rd(5'd12, rv); chk("status10", rv, ST0);
        chk("flush10", {31'd0, flush}, 32'd0);

        // Table-driven single exception/ERET cycles, each from a fresh reset.
        for (int k = 0; k < 11; k++) begin
            do_reset();
            slot_valid   = tbl[k].valid;
            slot_ds      = tbl[k].ds;
            slot_eret    = tbl[k].eret;
            slot_exc     = {tbl[k].e1, tbl[k].e0};
            slot_pc      = {tbl[k].pc1, tbl[k].pc0};
            slot_badaddr = {tbl[k].ba1, tbl[k].ba0};
            #1;
            chk($sformatf("v%0d_flush", k), {31'd0, flush}, {31'd0, tbl[k].xf});
            chk($sformatf("v%0d_fpc", k), flush_pc, tbl[k].xpc);
            chk($sformatf("v%0d_slot", k), {30'd0, exc_slot}, {30'd0, tbl[k].xslot});
            step();
            idle();
            rd(5'd13, rv); chk($sformatf("v%0d_cause", k), rv, tbl[k].xcause);
            rd(5'd14, rv); chk($sformatf("v%0d_epc", k), rv, tbl[k].xepc);
            rd(5'd8, rv);  chk($sformatf("v%0d_bv", k), rv, tbl[k].xbv);
            rd(5'd12, rv); chk($sformatf("v%0d_status", k), rv, tbl[k].xstat);
        end

        // Hardware interrupt: synchroniser latency, taken at slot 0.
        do_reset();
        mtc0(5'd12, 32'h00000401, 2'd0);
        hw_int = 6'h01;
        slot_valid = 2'b01; slot_pc = {32'h0, 32'h80000200};
        step();
        #1; chk("int_e1_flush", {31'd0, flush}, 32'd0);
        step();
        chk("int_e2_flush", {31'd0, flush}, 32'd1);
        chk("int_e2_slot", {30'd0, exc_slot}, 32'd1);
        chk("int_e2_fpc", flush_pc, VEC);
        step();
        slot_valid = 2'b00;
        rd(5'd13, rv); chk("int_cause", rv, 32'h00000400);
        rd(5'd12, rv); chk("int_status", rv, 32'h00400403);
        rd(5'd14, rv); chk("int_epc", rv, 32'h80000200);
        slot_valid = 2'b01;
        #1; chk("int_masked", {31'd0, flush}, 32'd0);
        idle();
        hw_int = 6'd0;

        // Nested exception keeps EPC/BD, then ERET returns to the original EPC.
        do_reset();
        slot_valid = 2'b01; slot_exc = {7'h00, 7'h08}; slot_pc = {32'h0, 32'h80000040};
        step();
        idle();
        slot_valid = 2'b01; slot_exc = {7'h00, 7'h20}; slot_pc = {32'h0, 32'h80000080}; slot_ds = 2'b01;
        #1; chk("nest_flush", {31'd0, flush}, 32'd1);
        step();
        idle();
        rd(5'd14, rv); chk("nest_epc", rv, 32'h80000040);
        rd(5'd13, rv); chk("nest_cause", rv, 32'h00000028);
        rd(5'd12, rv); chk("nest_status", rv, ST0 | 2);
        slot_valid = 2'b01; slot_eret = 2'b01;
        #1;
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_fpc", flush_pc, 32'h80000040);
        chk("eret_slot", {30'd0, exc_slot}, 32'd0);
        step();
        idle();
        rd(5'd12, rv); chk("eret_status", rv, ST0);
        rd(5'd14, rv); chk("eret_epc", rv, 32'h80000040);

        // MTC0 gating by exceptions in older/same slots, and EXL override.
        do_reset();
        slot_valid = 2'b11; slot_exc = {7'h10, 7'h00};
        mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_wdata = 32'd5; mtc0_slot = 2'd1;
        step();
        idle();
        rd(5'd11, rv); chk("mtc0_blocked", rv, 32'd0);
        slot_valid = 2'b11; slot_exc = {7'h10, 7'h00};
        mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_wdata = 32'd5; mtc0_slot = 2'd0;
        step();
        idle();
        rd(5'd11, rv); chk("mtc0_older_ok", rv, 32'd5);
        slot_valid = 2'b11; slot_exc = {7'h10, 7'h00};
        mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0000ff01; mtc0_slot = 2'd0;
        step();
        idle();
        rd(5'd12, rv); chk("exl_override", rv, 32'h0040ff03);

        // Cause write mask, unmapped address, Count load and wrap.
        do_reset();
        mtc0(5'd13, 32'hffffffff, 2'd0);
        rd(5'd13, rv); chk("cause_wmask", rv, 32'h00000300);
        mtc0(5'd3, 32'h00001234, 2'd0);
        rd(5'd3, rv);  chk("unmapped", rv, 32'd0);
        do_reset();
        step();
        mtc0(5'd9, 32'hfffffffe, 2'd0);
        rd(5'd9, rv); chk("count_load", rv, 32'hfffffffe);
        step();
        rd(5'd9, rv); chk("count_divclr", rv, 32'hfffffffe);
        step();
        rd(5'd9, rv); chk("count_ffff", rv, 32'hffffffff);
        step(); step();
        rd(5'd9, rv); chk("count_wrap", rv, 32'd0);

        // Timer interrupt (or its absence in the default build).
        do_reset();
        mtc0(5'd11, 32'd3, 2'd0);
        mtc0(5'd9, 32'd0, 2'd0);
        for (int c = 0; c < 5; c++) step();
        rd(5'd13, rv); chk("ti_before", rv, 32'd0);
        step();
        rd(5'd9, rv);  chk("ti_count3", rv, 32'd3);
        rd(5'd13, rv); chk("ti_set", rv, TIMER_ON ? 32'h40008000 : 32'h0);
        step(); step();
        rd(5'd13, rv); chk("ti_held", rv, TIMER_ON ? 32'h40008000 : 32'h0);
        mtc0(5'd11, 32'd100, 2'd0);
        rd(5'd13, rv); chk("ti_clear", rv, 32'd0);
        rd(5'd11, rv); chk("compare_rw", rv, 32'd100);

        // IP7 source: hw_int[5] only without the timer option.
        do_reset();
        hw_int = 6'h20;
        step(); step();
        rd(5'd13, rv); chk("ip7_src", rv, TIMER_ON ? 32'h0 : 32'h00008000);
        hw_int = 6'd0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter ISSUE_W, 2, number of commit slots (1..4); slot 0 is the oldest.
REQ-002 Parameter TICK_DIV, 2, clocks per Count increment (1..16).
REQ-003 Parameter EXC_VECTOR, 32'hbfc00380, exception entry PC.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 slot_valid  in  ISSUE_W  slot commits this cycle.
REQ-007 slot_pc  in  32*ISSUE_W  PC per slot.
REQ-008 slot_ds  in  ISSUE_W  slot is in a branch delay slot.
REQ-009 slot_exc  in  7*ISSUE_W  per slot {if_adel, ri, ov, sys, bp, adel, ades}, if_adel in the MSB.
REQ-010 slot_badaddr  in  32*ISSUE_W  data bad address per slot.
REQ-011 slot_eret  in  ISSUE_W  slot is ERET.
REQ-012 mtc0_we, mtc0_slot, mtc0_addr, mtc0_wdata  in  1, 2, 5, 32  CP0 write port.
REQ-013 mfc0_addr  in  5; mfc0_rdata  out  32  combinational CP0 read.
REQ-014 hw_int  in  6  asynchronous external interrupt lines.
REQ-015 flush  out  1; flush_pc  out  32; exc_slot  out  ISSUE_W one-hot  redirect request.

Function
REQ-016 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); any other address reads 0 and ignores writes.
REQ-017 hw_int passes through a 2-flop synchroniser; the synchronised value drives Cause.IP[7:2] each cycle.
REQ-018 Cause.IP[1:0] is writable only by MTC0; all other Cause bits are read-only to MTC0.
REQ-019 Status writable bits: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all other bits read 0.
REQ-020 A divider counter increments Count once every TICK_DIV clocks; Count wraps 0xFFFFFFFF->0.
REQ-021 MTC0 to Count loads the value and clears the divider; it wins over a same-cycle tick.
REQ-022 The interrupt is pending when Status.IE=1, Status.EXL=0, and (Cause.IP & Status.IM) != 0.
REQ-023 A pending interrupt is attributed to slot 0 and is taken only when slot_valid[0]=1.
REQ-024 The excepting slot is the lowest-index valid slot with any exc bit set, or with an interrupt attributed to it.
REQ-025 Intra-slot priority: Int(0) > if_adel AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > adel AdEL(4) > ades AdES(5); only the winner's ExcCode is written.
REQ-026 On an exception: flush=1, flush_pc=EXC_VECTOR, exc_slot=one-hot of that slot (all combinational, same cycle).
REQ-027 On an exception, at the edge: ExcCode is written; Status.EXL is set to 1.
REQ-028 On an exception with EXL=0 beforehand, at the edge: EPC = pc-4 if ds else pc; Cause.BD = ds.
REQ-029 On an exception with EXL=1 beforehand, EPC and BD are unchanged.
REQ-030 BadVAddr is loaded with slot_pc for if_adel, and with slot_badaddr for adel/ades; it is unchanged otherwise.
REQ-031 ERET in a valid slot with no older or same-slot exception: flush=1, flush_pc=EPC, exc_slot=0, and EXL is cleared at the edge.
REQ-032 An exception in any slot wins over an ERET in a younger slot.
REQ-033 An MTC0 is applied only if mtc0_slot is younger-index-free of exceptions, i.e. no exception in slot <= mtc0_slot.
REQ-034 An exception-set EXL overrides an MTC0 Status write in the same cycle.
REQ-035 mfc0_rdata returns pre-edge register values; there is no bypass of same-cycle writes.

Reset
REQ-036 When rst=0: all registers are 0 except Status=0x00400000; the divider is 0; the synchroniser is 0.
REQ-037 Outputs during reset: flush=0, flush_pc=EXC_VECTOR, exc_slot=0; mfc0_rdata reflects the reset values.
REQ-038 Reset asserted mid-exception discards the pending update; no partial EPC/Cause write occurs.

Configuration
REQ-039 With CP0_TIMER_INT_EN defined: when Count becomes equal to Compare (increment or write), Cause.IP[7] (TI, bit 30) is set and held; it overrides hw_int[5] at IP7.
REQ-040 With CP0_TIMER_INT_EN defined: an MTC0 to Compare clears IP7 and TI.
REQ-041 Without CP0_TIMER_INT_EN: IP7 follows hw_int[5]; Compare remains a read/write register; TI reads 0.

Verification
REQ-042 Reset released, 10 clocks, TICK_DIV=2 -> Count=5, Status=0x00400000, flush=0.
REQ-043 Slot1 ov=1 with ds=1, pc=0x80001004, EXL=0 -> flush=1, flush_pc=0xbfc00380, exc_slot=2'b10; after the edge EPC=0x80001000, BD=1, ExcCode=12.
REQ-044 Slot0 sys and slot1 eret in the same cycle -> ExcCode=8, flush_pc=EXC_VECTOR, EXL=1.
REQ-045 Status=0x00000401 (IM2, IE=1), hw_int[0] rises -> interrupt taken at slot 0 on the third edge, ExcCode=0.
REQ-046 Timer enabled, Compare=3, Count=0 -> TI=1 once Count=3; MTC0 to Compare clears TI.
REQ-047 Exception with EXL=1, then ERET -> EPC unchanged; after the ERET, EXL=0 and flush_pc equals the original EPC.
